// File: rtl/siphash_req_arbiter.sv
// Round-robin front end that shares one fixed-latency SipHash core between NUM_REQ requesters.
// A tag pipe follows each issue through the core, and a credited response FIFO collects the results.
module siphash_req_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int CORE_LAT   = 10,
  parameter int FIFO_DEPTH = 8,
  parameter int ID_W       = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*256-1:0] req_key,
  input  logic [NUM_REQ*64-1:0]  req_nonce,
  input  logic                   drain,
  output logic                   core_we,
  output logic [255:0]           core_key,
  output logic [63:0]            core_nonce,
  input  logic [63:0]            core_result,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [63:0]            rsp_result,
  output logic                   idle
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state;
  logic            armed;
  logic [ID_W-1:0] rr_ptr, gnt_id, idx;
  logic [CW-1:0]   credits;
  logic            issue, pop;

  // armed keeps req_ready low through reset even when requesters hold req_valid high
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    idx       = '0;
    issue     = 1'b0;
    if (armed && state == RUN && credits != '0) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
        if (req_valid[idx]) begin
          issue  = 1'b1;
          gnt_id = idx;
        end
      end
    end
    if (issue) req_ready[gnt_id] = 1'b1;
  end

  assign core_we    = issue;
  assign core_key   = issue ? req_key[256*gnt_id +: 256] : '0;
  assign core_nonce = issue ? req_nonce[64*gnt_id +: 64] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RUN;
      armed   <= 1'b0;
      rr_ptr  <= '0;
      credits <= CW'(FIFO_DEPTH);
      idle    <= 1'b0;
    end else begin
      armed <= 1'b1;
      case (state)
        RUN:   if (drain)  state <= DRAIN;
        DRAIN: if (!drain) state <= RUN;
      endcase
      idle <= (state == DRAIN) && (credits == CW'(FIFO_DEPTH));
      if (issue) rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      case ({issue, pop})
        2'b10:   credits <= credits - 1'b1;
        2'b01:   credits <= credits + 1'b1;
        default: ;
      endcase
    end
  end

  // Tag pipe mirrors the core latency; only valid stages ever reach the FIFO
  logic [CORE_LAT-1:0]           vld_pipe;
  logic [CORE_LAT-1:0][ID_W-1:0] id_pipe;
  logic                          wr;
  logic [ID_W-1:0]               wr_id;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      id_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[CORE_LAT-2:0], issue};
      id_pipe  <= {id_pipe[CORE_LAT-2:0], gnt_id};
    end
  end

  assign wr    = vld_pipe[CORE_LAT-1];
  assign wr_id = id_pipe[CORE_LAT-1];

  logic [ID_W-1:0] mem_id  [FIFO_DEPTH];
  logic [63:0]     mem_res [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0]   count, count_nxt;
  logic            bypass;

  assign pop        = rsp_valid & rsp_ready;
  assign rd_ptr_nxt = rd_ptr + PW'(pop);
  assign count_nxt  = count + CW'(wr) - CW'(pop);
  // Write into an effectively empty FIFO goes straight to the head registers
  assign bypass     = wr && ((count - CW'(pop)) == '0);

  always_ff @(posedge clk) begin
    if (wr) begin
      mem_id[wr_ptr]  <= wr_id;
      mem_res[wr_ptr] <= core_result;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
    end else begin
      wr_ptr    <= wr_ptr + PW'(wr);
      rd_ptr    <= rd_ptr_nxt;
      count     <= count_nxt;
      rsp_valid <= count_nxt != '0;
      if (bypass) begin
        rsp_id     <= wr_id;
        rsp_result <= core_result;
      end else if (pop) begin
        rsp_id     <= mem_id[rd_ptr_nxt];
        rsp_result <= mem_res[rd_ptr_nxt];
      end
    end
  end
endmodule
